frame_sync_ctrl: RTL and testbench

FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

---
 rtl/frame_sync_ctrl.sv | 157 +++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: pauses the SNES on a chosen line until the HDMI side
// reaches its first line, so the two frame timings line up. Pauses always
// last an even number of cycles to keep the PPU SDRAM phase intact.
module frame_sync_ctrl #(
  parameter logic [7:0]  SYNC_LINE   = 8'd2,
  parameter logic [7:0]  REARM_LINE  = 8'd200,
  parameter logic [19:0] TIMEOUT     = 20'd400000,
  parameter int          LOCK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  ys,
  input  logic        snes_refresh,
  input  logic        hdmi_first_line,
  output logic        pause,
  output logic        sync_done,
  output logic        lock,
  output logic [7:0]  timeout_cnt,
  output logic [19:0] pause_len
);

  localparam int          LW         = $clog2(LOCK_FRAMES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);
  localparam logic [19:0] PCNT_MAX   = 20'hFFFFF;
  localparam logic [19:0] TIMEOUT_M1 = TIMEOUT - 20'd1;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    PAUSE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    hs_sync_reg;
  logic          hs;
  logic          parity_reg, parity_next;
  logic [19:0]   pcnt_reg, pcnt_next;
  logic [19:0]   pcnt_inc;
  logic [LW-1:0] lock_run_reg, lock_run_next;
  logic [7:0]    timeout_cnt_reg, timeout_cnt_next;
  logic [19:0]   pause_len_reg, pause_len_next;
  logic          pause_reg, sync_done_reg, lock_reg;
  logic [7:0]    line;
  logic          ys_field_unused;

  // The field bit carries no information for line matching.
  assign line            = ys[7:0];
  assign ys_field_unused = ys[8];

  assign hs       = hs_sync_reg[1];
  assign pcnt_inc = (pcnt_reg == PCNT_MAX) ? PCNT_MAX : pcnt_reg + 20'd1;

  // Two-flop synchronizer bringing the pixel-domain first-line level into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sync_reg <= 2'b00;
    end else begin
      hs_sync_reg <= {hs_sync_reg[0], hdmi_first_line};
    end
  end

  // State and counter registers; pause/sync_done/lock follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ARMED;
      parity_reg      <= 1'b0;
      pcnt_reg        <= '0;
      lock_run_reg    <= '0;
      timeout_cnt_reg <= '0;
      pause_len_reg   <= '0;
      pause_reg       <= 1'b0;
      sync_done_reg   <= 1'b0;
      lock_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      parity_reg      <= parity_next;
      pcnt_reg        <= pcnt_next;
      lock_run_reg    <= lock_run_next;
      timeout_cnt_reg <= timeout_cnt_next;
      pause_len_reg   <= pause_len_next;
      pause_reg       <= (state_next == PAUSE);
      sync_done_reg   <= (state_next == DONE);
      lock_reg        <= (lock_run_next == LOCK_MAX);
    end
  end

  // Next-state logic: arm on the sync line, hold the pause in cycle pairs,
  // leave on a clean sync, a timeout or a bypass request.
  always_comb begin
    state_next       = state_reg;
    parity_next      = parity_reg;
    pcnt_next        = pcnt_reg;
    lock_run_next    = lock_run_reg;
    timeout_cnt_next = timeout_cnt_reg;
    pause_len_next   = pause_len_reg;

    case (state_reg)
      ARMED: begin
        if (enable && (line == SYNC_LINE) && snes_refresh) begin
          state_next  = PAUSE;
          parity_next = 1'b0;
          pcnt_next   = '0;
        end
      end

      PAUSE: begin
        parity_next = ~parity_reg;
        pcnt_next   = pcnt_inc;
        // Exits only on odd parity so the paused-cycle count stays even.
        if (parity_reg) begin
          if (!enable) begin
            state_next     = ARMED;
            lock_run_next  = '0;
            pause_len_next = pcnt_inc;
          end else if (hs) begin
            // A clean sync wins even if the timeout is reached this cycle.
            state_next     = DONE;
            pause_len_next = pcnt_inc;
            if (lock_run_reg != LOCK_MAX) begin
              lock_run_next = lock_run_reg + 1'b1;
            end
          end else if (pcnt_reg >= TIMEOUT_M1) begin
            state_next     = DONE;
            pause_len_next = pcnt_inc;
            lock_run_next  = '0;
            if (timeout_cnt_reg != 8'hFF) begin
              timeout_cnt_next = timeout_cnt_reg + 8'd1;
            end
          end
        end
      end

      DONE: begin
        if (line == REARM_LINE) begin
          state_next = ARMED;
        end
      end

      default: begin
        state_next = ARMED;
      end
    endcase

    // In bypass the lock history is discarded once per frame.
    if (!enable && (line == REARM_LINE)) begin
      lock_run_next = '0;
    end
  end

  assign pause       = pause_reg;
  assign sync_done   = sync_done_reg;
  assign lock        = lock_reg;
  assign timeout_cnt = timeout_cnt_reg;
  assign pause_len   = pause_len_reg;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb_frame_sync_ctrl: frame-level stimulus table with a scoreboard queue of
// expected frame outcomes, plus hand-written reset and gating sequences.
module tb_frame_sync_ctrl;

  localparam logic [8:0] SYNC_YS  = 9'd2;
  localparam logic [8:0] REARM_YS = 9'd200;
  localparam logic [8:0] IDLE_YS  = 9'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [8:0]  ys;
  logic        snes_refresh;
  logic        hdmi_first_line;
  logic        pause;
  logic        sync_done;
  logic        lock;
  logic [7:0]  timeout_cnt;
  logic [19:0] pause_len;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_sync_ctrl #(
    .SYNC_LINE   (8'd2),
    .REARM_LINE  (8'd200),
    .TIMEOUT     (20'd1000),
    .LOCK_FRAMES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .ys              (ys),
    .snes_refresh    (snes_refresh),
    .hdmi_first_line (hdmi_first_line),
    .pause           (pause),
    .sync_done       (sync_done),
    .lock            (lock),
    .timeout_cnt     (timeout_cnt),
    .pause_len       (pause_len)
  );

  // One frame: hs_at = pause cycle in which the synchronized hs is first
  // high (0 = already high before the pause, -1 = never); abort_at = pause
  // cycle after which enable drops (-1 = never).
  typedef struct {
    logic        en;
    int          hs_at;
    int          abort_at;
    int          exp_cycles;
    int          exp_len;
    logic        exp_done;
    int          exp_tmo;
    logic        exp_lock;
  } frame_t;

  frame_t tbl[9];
  frame_t sb_q[$];

  function automatic frame_t mk(input logic en, input int hs_at, input int abort_at,
                                input int cyc, input int len, input logic done,
                                input int tmo, input logic lk);
    frame_t f;
    f.en = en; f.hs_at = hs_at; f.abort_at = abort_at; f.exp_cycles = cyc;
    f.exp_len = len; f.exp_done = done; f.exp_tmo = tmo; f.exp_lock = lk;
    return f;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one frame from the sync line through re-arm and scores it.
  task automatic run_frame(input int id, input frame_t f);
    int     j;
    int     high;
    bit     seen_low;
    frame_t e;
    if (f.hs_at == 0) begin
      hdmi_first_line = 1'b1;
      repeat (3) @(negedge clk);
    end
    enable       = f.en;
    ys           = SYNC_YS;
    snes_refresh = 1'b1;
    sb_q.push_back(f);
    @(negedge clk);
    ys           = IDLE_YS;
    snes_refresh = 1'b0;
    high     = 0;
    j        = 0;
    seen_low = 1'b0;
    while (!seen_low && j < 2000) begin
      if (pause) begin
        high++;
        if (f.hs_at >= 3 && j == f.hs_at - 3) hdmi_first_line = 1'b1;
        if (f.abort_at > 0 && j == f.abort_at - 1) enable = 1'b0;
        @(negedge clk);
        j++;
      end else begin
        seen_low = 1'b1;
      end
    end
    check($sformatf("frame%0d_terminated", id), int'(seen_low), 1);
    e = sb_q.pop_front();
    check($sformatf("frame%0d_pause_cycles", id), high, e.exp_cycles);
    check($sformatf("frame%0d_pause_len", id), int'(pause_len), e.exp_len);
    check($sformatf("frame%0d_sync_done", id), int'(sync_done), int'(e.exp_done));
    check($sformatf("frame%0d_timeout_cnt", id), int'(timeout_cnt), e.exp_tmo);
    check($sformatf("frame%0d_lock", id), int'(lock), int'(e.exp_lock));
    $display("frame %0d: en=%0d pause_cycles=%0d pause_len=%0d sync_done=%0d timeout_cnt=%0d lock=%0d",
             id, f.en, high, pause_len, sync_done, timeout_cnt, lock);
    hdmi_first_line = 1'b0;
    ys = REARM_YS;
    @(negedge clk);
    ys = IDLE_YS;
    check($sformatf("frame%0d_rearm_sync_done", id), int'(sync_done), 0);
    check($sformatf("frame%0d_rearm_pause", id), int'(pause), 0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(1'b1,    0, -1,    2,    2, 1'b1, 0, 1'b0); // hs from first cycle
    tbl[1] = mk(1'b1,  101, -1,  102,  102, 1'b1, 0, 1'b0); // hs on even parity
    tbl[2] = mk(1'b1,   50, -1,   50,   50, 1'b1, 0, 1'b0); // hs on odd parity
    tbl[3] = mk(1'b1,    7, -1,    8,    8, 1'b1, 0, 1'b1); // 4th clean -> lock
    tbl[4] = mk(1'b1,   -1, -1, 1000, 1000, 1'b1, 1, 1'b0); // timeout drops lock
    tbl[5] = mk(1'b1,   -1, 10,   10,   10, 1'b0, 1, 1'b0); // enable abort
    tbl[6] = mk(1'b0,   -1, -1,    0,   10, 1'b0, 1, 1'b0); // bypass: no pause
    tbl[7] = mk(1'b1,   20, -1,   20,   20, 1'b1, 1, 1'b0); // clean again
    tbl[8] = mk(1'b1, 1000, -1, 1000, 1000, 1'b1, 1, 1'b0); // hs with timeout

    reset           = 1'b1;
    enable          = 1'b1;
    ys              = IDLE_YS;
    snes_refresh    = 1'b0;
    hdmi_first_line = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_pause", int'(pause), 0);
    check("reset_sync_done", int'(sync_done), 0);
    check("reset_lock", int'(lock), 0);
    check("reset_timeout_cnt", int'(timeout_cnt), 0);
    check("reset_pause_len", int'(pause_len), 0);

    for (int i = 0; i < 9; i++) begin
      run_frame(i, tbl[i]);
    end

    // Reset in the middle of a pause drops pause at once and clears all state.
    enable       = 1'b1;
    ys           = SYNC_YS;
    snes_refresh = 1'b1;
    @(negedge clk);
    ys           = IDLE_YS;
    snes_refresh = 1'b0;
    repeat (5) @(negedge clk);
    check("midpause_pause_before_reset", int'(pause), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_pause", int'(pause), 0);
    check("midreset_sync_done", int'(sync_done), 0);
    check("midreset_lock", int'(lock), 0);
    check("midreset_timeout_cnt", int'(timeout_cnt), 0);
    check("midreset_pause_len", int'(pause_len), 0);
    $display("reset mid-pause: pause=%0d timeout_cnt=%0d pause_len=%0d", pause, timeout_cnt, pause_len);
    reset = 1'b0;
    @(negedge clk);

    // Re-arm line while armed, and the sync line without refresh, do nothing.
    ys = REARM_YS;
    repeat (2) @(negedge clk);
    check("armed_rearm_pause", int'(pause), 0);
    check("armed_rearm_sync_done", int'(sync_done), 0);
    ys = SYNC_YS;
    snes_refresh = 1'b0;
    repeat (2) @(negedge clk);
    check("no_refresh_pause", int'(pause), 0);
    $display("gating: sync line without refresh, pause=%0d", pause);
    ys = IDLE_YS;
    @(negedge clk);

    run_frame(9, mk(1'b1, 3, -1, 4, 4, 1'b1, 0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
